// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared opcodes, state encoding and control-word layout for the multicycle control FSM.
package multicycle_ctrl_fsm_pkg;

  localparam int unsigned STATE_W = 4;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Datapath mux encodings
  localparam logic       SRC_A_PC      = 1'b0;
  localparam logic       SRC_A_RS1     = 1'b1;
  localparam logic [1:0] SRC_B_RS2     = 2'd0;
  localparam logic [1:0] SRC_B_FOUR    = 2'd1;
  localparam logic [1:0] SRC_B_IMM     = 2'd2;
  localparam logic [1:0] ALU_ADD       = 2'd0;
  localparam logic [1:0] ALU_BRANCH    = 2'd1;
  localparam logic [1:0] ALU_FUNCT     = 2'd2;
  localparam logic [1:0] WB_ALUOUT     = 2'd0;
  localparam logic [1:0] WB_MDR        = 2'd1;
  localparam logic [1:0] WB_ALU_LIVE   = 2'd2;
  localparam logic       PC_SRC_ALU    = 1'b0;
  localparam logic       PC_SRC_ALUOUT = 1'b1;

  typedef enum logic [STATE_W-1:0] {
    S_IF        = 4'd0,
    S_ID        = 4'd1,
    S_EX_R      = 4'd2,
    S_EX_I      = 4'd3,
    S_EX_ADDR   = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_ALU    = 4'd7,
    S_WB_MEM    = 4'd8,
    S_BR        = 4'd9,
    S_PC_INC    = 4'd10,
    S_JALR_ADDR = 4'd11,
    S_LINK      = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       pc_source;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_ctrl_decode.sv
// Pure state -> datapath control word decode (Moore), except ir_write which follows fetch completion.
module multicycle_ctrl_fsm_ctrl_decode
  import multicycle_ctrl_fsm_pkg::*;
(
  input  state_t state,
  input  logic   fetch_done,
  output ctrl_t  ctrl
);

  // Control word per state; unknown encodings leave everything at 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        ctrl.ir_write = fetch_done;
      end
      S_ID: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_EX_R: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_RS2;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EX_I: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_EX_ADDR, S_JALR_ADDR: begin
        ctrl.alu_src_a = SRC_A_RS1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_WB_ALU, S_WB_MEM: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = (state == S_WB_MEM) ? WB_MDR : WB_ALUOUT;
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_ALU;
      end
      S_BR: begin
        ctrl.alu_src_a     = SRC_A_RS1;
        ctrl.alu_src_b     = SRC_B_RS2;
        ctrl.alu_op        = ALU_BRANCH;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
      end
      S_PC_INC: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_ALU;
      end
      S_LINK: begin
        ctrl.alu_src_a = SRC_A_PC;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU_LIVE;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_SRC_ALUOUT;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// RV32I multicycle control FSM: state register, sequencing, halt flag and retire counter.
module multicycle_ctrl_fsm
  import multicycle_ctrl_fsm_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned HALT_CODE     = 10,
  parameter int unsigned MEM_HANDSHAKE = 1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [6:0]       opcode,
  input  logic [XLEN-1:0]  x17_val,
  input  logic             bcond,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             pc_source,
  output logic             is_halted,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t           state;
  state_t           state_nxt;
  logic             mem_go;
  logic             illegal_c;
  logic             halted;
  logic [CNT_W-1:0] retire_q;
  ctrl_t            ctrl;
  ctrl_t            ctrl_out;

  // Without a handshake every memory access completes in its first cycle
  assign mem_go = (MEM_HANDSHAKE == 0) ? 1'b1 : mem_ready;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IF;
    else          state <= state_nxt;
  end

  // Next-state sequencing and illegal-opcode detect in ID
  always_comb begin
    state_nxt = S_IF;
    illegal_c = 1'b0;
    case (state)
      S_IF: state_nxt = mem_go ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_R:      state_nxt = S_EX_R;
          OP_IMM:    state_nxt = S_EX_I;
          OP_LOAD,
          OP_STORE:  state_nxt = S_EX_ADDR;
          OP_BRANCH: state_nxt = S_BR;
          OP_JAL:    state_nxt = S_LINK;
          OP_JALR:   state_nxt = S_JALR_ADDR;
          OP_SYSTEM: state_nxt = (x17_val == XLEN'(HALT_CODE)) ? S_HALT : S_PC_INC;
          default: begin
            state_nxt = S_PC_INC;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_EX_R, S_EX_I: state_nxt = S_WB_ALU;
      S_EX_ADDR:      state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:       state_nxt = mem_go ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:       state_nxt = mem_go ? S_PC_INC : S_MEM_WR;
      S_BR:           state_nxt = bcond ? S_IF : S_PC_INC;
      S_JALR_ADDR:    state_nxt = S_LINK;
      S_HALT:         state_nxt = S_HALT;
      default:        state_nxt = S_IF;
    endcase
  end

  // Sticky halt flag, set as the FSM enters HALT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 halted <= 1'b0;
    else if (state_nxt == S_HALT) halted <= 1'b1;
  end

  // Count each return to IF from any other state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                               retire_q <= '0;
    else if (state != S_IF && state_nxt == S_IF) retire_q <= retire_q + CNT_W'(1);
  end

  multicycle_ctrl_fsm_ctrl_decode u_ctrl_decode (
    .state      (state),
    .fetch_done (mem_go),
    .ctrl       (ctrl)
  );

  // Strobes are held low for as long as reset is asserted
  assign ctrl_out      = reset_n ? ctrl : ctrl_t'('0);
  assign pc_write      = ctrl_out.pc_write;
  assign pc_write_cond = ctrl_out.pc_write_cond;
  assign iord          = ctrl_out.iord;
  assign mem_read      = ctrl_out.mem_read;
  assign mem_write     = ctrl_out.mem_write;
  assign ir_write      = ctrl_out.ir_write;
  assign reg_write     = ctrl_out.reg_write;
  assign alu_src_a     = ctrl_out.alu_src_a;
  assign alu_src_b     = ctrl_out.alu_src_b;
  assign alu_op        = ctrl_out.alu_op;
  assign wb_sel        = ctrl_out.wb_sel;
  assign pc_source     = ctrl_out.pc_source;
  assign illegal_op    = reset_n & illegal_c;
  assign is_halted     = halted;
  assign retire_cnt    = retire_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: random instruction stream with planned memory waits against a per-instruction timing model.
module tb_multicycle_ctrl_fsm;

  localparam logic [6:0] T_R      = 7'h33;
  localparam logic [6:0] T_I      = 7'h13;
  localparam logic [6:0] T_LD     = 7'h03;
  localparam logic [6:0] T_ST     = 7'h23;
  localparam logic [6:0] T_BR     = 7'h63;
  localparam logic [6:0] T_JAL    = 7'h6f;
  localparam logic [6:0] T_JALR   = 7'h67;
  localparam logic [6:0] T_SYS    = 7'h73;

  typedef enum int {K_R, K_I, K_LD, K_ST, K_BR, K_JAL, K_JALR, K_SYS, K_ILL} kind_e;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic [31:0] x17_val;
  logic        bcond;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write;
  logic        alu_src_a, pc_source, is_halted, illegal_op;
  logic [1:0]  alu_src_b, alu_op, wb_sel;
  logic [31:0] retire_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_retire;
  logic [6:0]  ill_ops [5];

  multicycle_ctrl_fsm dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .x17_val(x17_val), .bcond(bcond),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .wb_sel(wb_sel),
    .pc_source(pc_source), .is_halted(is_halted), .illegal_op(illegal_op), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] strobes();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, illegal_op};
  endfunction

  function automatic logic [6:0] sel_word();
    return {alu_src_a, alu_src_b, alu_op, wb_sel};
  endfunction

  // Runs one instruction from its first IF cycle; mem_ready follows the planned wait counts
  task automatic run_instr(input kind_e k, input int if_w, input int mem_w, input logic bc,
                           input logic [6:0] ill, input logic [31:0] x17);
    int n, m0, base;
    int n_rd, n_wr, n_iord, n_ir, n_rg, n_pc, n_pcc, n_ill, n_fn;
    logic [5:0] pcw, pcc;
    logic [2:0] fn;
    logic [1:0] wb_seen;
    logic [6:0] op;
    logic is_mem, writes_reg;
    logic [5:0] exp_pcw;
    is_mem     = (k == K_LD) || (k == K_ST);
    writes_reg = (k == K_R) || (k == K_I) || (k == K_LD) || (k == K_JAL) || (k == K_JALR);
    case (k)
      K_R:     begin op = T_R;    base = 4; end
      K_I:     begin op = T_I;    base = 4; end
      K_LD:    begin op = T_LD;   base = 5; end
      K_ST:    begin op = T_ST;   base = 5; end
      K_BR:    begin op = T_BR;   base = bc ? 3 : 4; end
      K_JAL:   begin op = T_JAL;  base = 3; end
      K_JALR:  begin op = T_JALR; base = 4; end
      K_SYS:   begin op = T_SYS;  base = 3; end
      default: begin op = ill;    base = 3; end
    endcase
    n  = base + if_w + (is_mem ? mem_w : 0);
    m0 = if_w + 3;
    {n_rd, n_wr, n_iord, n_ir, n_rg, n_pc, n_pcc, n_ill, n_fn} = '0;
    pcw = '0; pcc = '0; fn = '0; wb_seen = '0;
    for (int c = 0; c < n; c++) begin
      bcond   = bc;
      x17_val = x17;
      if (c <= if_w) begin
        mem_ready = (c == if_w);
        opcode    = 7'($urandom);
      end else begin
        opcode = op;
        if (is_mem && c >= m0) mem_ready = (c == m0 + mem_w);
        else                   mem_ready = 1'($urandom);
      end
      @(negedge clk);
      if (mem_read)  n_rd++;
      if (mem_write) n_wr++;
      if (iord)      n_iord++;
      if (ir_write)  n_ir++;
      if (illegal_op) n_ill++;
      if (reg_write) begin n_rg++; wb_seen = wb_sel; end
      if (pc_write)      begin n_pc++;  pcw = {pc_source, alu_src_a, alu_src_b, alu_op}; end
      if (pc_write_cond) begin n_pcc++; pcc = {pc_source, alu_src_a, alu_src_b, alu_op}; end
      if (alu_op == 2'd2) begin n_fn++; fn = {alu_src_a, alu_src_b}; end
      @(posedge clk); #1;
    end
    exp_retire = exp_retire + 1;
    check("n_mem_read",  32'(n_rd),   32'(if_w + 1 + ((k == K_LD) ? mem_w + 1 : 0)));
    check("n_mem_write", 32'(n_wr),   32'((k == K_ST) ? mem_w + 1 : 0));
    check("n_iord",      32'(n_iord), 32'(is_mem ? mem_w + 1 : 0));
    check("n_ir_write",  32'(n_ir),   32'd1);
    check("n_reg_write", 32'(n_rg),   32'(writes_reg));
    check("n_pc_write",  32'(n_pc),   32'((k == K_BR && bc) ? 0 : 1));
    check("n_pc_cond",   32'(n_pcc),  32'(k == K_BR));
    check("n_illegal",   32'(n_ill),  32'(k == K_ILL));
    check("n_funct",     32'(n_fn),   32'((k == K_R || k == K_I) ? 1 : 0));
    if (writes_reg)
      check("wb_sel", 32'(wb_seen), (k == K_LD) ? 32'd1 : (k == K_JAL || k == K_JALR) ? 32'd2 : 32'd0);
    if (n_pc > 0) begin
      exp_pcw = (k == K_JAL || k == K_JALR) ? 6'b100100 : 6'b000100;
      check("pc_update_sel", 32'(pcw), 32'(exp_pcw));
    end
    if (k == K_BR)             check("branch_sel", 32'(pcc), 32'(6'b110001));
    if (k == K_R || k == K_I)  check("funct_sel", 32'(fn), (k == K_R) ? 32'(3'b100) : 32'(3'b110));
    check("retire_cnt", retire_cnt, exp_retire);
    check("back_in_fetch", 32'({mem_read, iord, mem_write, pc_write, reg_write, pc_write_cond}), 32'(6'b100000));
    check("not_halted", 32'(is_halted), 32'd0);
  endtask

  initial begin
    ill_ops[0] = 7'h7f; ill_ops[1] = 7'h37; ill_ops[2] = 7'h17; ill_ops[3] = 7'h00; ill_ops[4] = 7'h0f;
    exp_retire = '0;
    reset_n = 1'b0; mem_ready = 1'b1; opcode = '0; bcond = 1'b0; x17_val = '0;

    // Reset: everything quiet even with mem_ready high
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_strobes", 32'(strobes()), 32'd0);
    check("rst_sel", 32'({sel_word(), pc_source}), 32'd0);
    check("rst_retire", retire_cnt, 32'd0);
    check("rst_halted", 32'(is_halted), 32'd0);
    mem_ready = 1'b0;
    #2 reset_n = 1'b1;
    #1 check("rel_fetch", 32'({mem_read, ir_write, iord}), 32'(3'b100));
    repeat (3) begin
      @(posedge clk); #1;
      check("hold_if", 32'({mem_read, ir_write, iord, pc_write}), 32'(4'b1000));
    end
    check("hold_retire", retire_cnt, 32'd0);

    // Directed instructions
    run_instr(K_R,   0, 0, 1'b0, 7'h7f, 32'd0);
    run_instr(K_LD,  2, 3, 1'b0, 7'h7f, 32'd0);
    run_instr(K_ST,  0, 3, 1'b0, 7'h7f, 32'd0);
    run_instr(K_BR,  0, 0, 1'b1, 7'h7f, 32'd0);
    run_instr(K_BR,  0, 0, 1'b0, 7'h7f, 32'd0);
    run_instr(K_SYS, 0, 0, 1'b0, 7'h7f, 32'd9);
    run_instr(K_ILL, 0, 0, 1'b0, 7'h7f, 32'd10);
    run_instr(K_JAL, 1, 0, 1'b0, 7'h7f, 32'd0);
    run_instr(K_JALR,0, 0, 1'b0, 7'h7f, 32'd0);
    run_instr(K_I,   0, 0, 1'b0, 7'h7f, 32'd0);

    // Random instruction stream
    for (int i = 0; i < 150; i++) begin
      kind_e k;
      logic [31:0] x;
      k = kind_e'($urandom_range(0, 8));
      x = $urandom_range(0, 20);
      if (k == K_SYS && x == 32'd10) x = 32'd11;
      run_instr(k, int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'($urandom),
                ill_ops[$urandom_range(0, 4)], x);
    end

    // Reset in the middle of a store wait aborts it at once
    mem_ready = 1'b1; opcode = T_ST;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("mw_waiting", 32'({mem_write, iord}), 32'(2'b11));
    #1 reset_n = 1'b0;
    #1;
    check("mw_abort_strobes", 32'(strobes()), 32'd0);
    check("mw_abort_retire", retire_cnt, 32'd0);
    exp_retire = '0;
    #1 reset_n = 1'b1;
    #1;
    check("mw_rel_fetch", 32'({mem_read, iord, mem_write, pc_write}), 32'(4'b1000));
    @(posedge clk); #1;
    run_instr(K_R, 0, 0, 1'b0, 7'h7f, 32'd0);

    // ECALL with x17 = 10 halts for good
    mem_ready = 1'b1; opcode = 7'($urandom);
    @(posedge clk); #1;
    opcode = T_SYS; x17_val = 32'd10;
    @(negedge clk);
    check("ecall_id_not_halted", 32'(is_halted), 32'd0);
    check("ecall_id_not_illegal", 32'(illegal_op), 32'd0);
    @(posedge clk); #1;
    for (int c = 0; c < 100; c++) begin
      mem_ready = 1'($urandom); opcode = 7'($urandom); bcond = 1'($urandom);
      @(negedge clk);
      check("halted", 32'(is_halted), 32'd1);
      check("halt_strobes", 32'(strobes()), 32'd0);
      check("halt_retire", retire_cnt, exp_retire);
      @(posedge clk); #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
# multicycle_ctrl_fsm

Self-contained control FSM for the RV32I multicycle CPU. It owns its own state register, drives every datapath control strobe as a Moore function of state, and waits on a variable-latency memory handshake. It decodes ECALL exit via the x17 value and counts retired instructions. It sits between the instruction register / register file and the datapath muxes, replacing an external state latch plus next-state logic.

## Interface
- XLEN, 32: width of the x17 value input.
- HALT_CODE, 10: x17 value that makes ECALL halt.
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, every memory state lasts 1 cycle.
- CNT_W, 32: retire counter width.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0], valid from ID onward.
- x17_val  in  XLEN  register-file read of x17, sampled in ID.
- bcond  in  1  branch comparison result from ALU, sampled in BR.
- mem_ready  in  1  memory completes the current read/write this cycle.
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write  out  1 each  datapath strobes.
- alu_src_a  out  1  0 = PC, 1 = A register (rs1).
- alu_src_b  out  2  0 = B (rs2), 1 = constant 4, 2 = immediate.
- alu_op  out  2  0 = add, 1 = branch compare, 2 = funct-decoded.
- wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = live ALU result.
- pc_source  out  1  0 = live ALU result, 1 = ALUOut with bit 0 cleared.
- is_halted  out  1  sticky halt flag.
- illegal_op  out  1  one-cycle pulse in ID for an unsupported opcode.
- retire_cnt  out  CNT_W  instructions retired since reset.

## Operation
- States (4-bit): IF, ID, EX_R, EX_I, EX_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BR, PC_INC, JALR_ADDR, LINK, HALT.
- IF: iord=0, mem_read=1. ir_write=1 only in the cycle mem_ready=1 (always, if MEM_HANDSHAKE=0). Moves to ID on that cycle; otherwise holds.
- ID: a=PC, b=imm, add. ALUOut receives the branch/JAL target. Next state by opcode:
  - R → EX_R.
  - I-arith → EX_I.
  - load/store → EX_ADDR.
  - branch → BR.
  - JAL → LINK.
  - JALR → JALR_ADDR.
  - SYSTEM with x17_val==HALT_CODE → HALT.
  - other SYSTEM → PC_INC.
  - anything else → PC_INC with illegal_op=1.
- EX_R: a=rs1, b=rs2, funct; → WB_ALU. EX_I: a=rs1, b=imm, funct; → WB_ALU.
- EX_ADDR: a=rs1, b=imm, add; load → MEM_RD, store → MEM_WR.
- MEM_RD: iord=1, mem_read=1; holds until mem_ready; → WB_MEM. MEM_WR: iord=1, mem_write=1; holds until mem_ready; → PC_INC.
- WB_ALU: reg_write, wb_sel=0; concurrently a=PC, b=4, add, pc_write, pc_source=0; → IF.
- WB_MEM: as WB_ALU but wb_sel=1.
- BR: a=rs1, b=rs2, compare; pc_write_cond=1, pc_source=1. bcond=1 → IF (target taken); bcond=0 → PC_INC.
- PC_INC: a=PC, b=4, add, pc_write, pc_source=0; → IF.
- JALR_ADDR: a=rs1, b=imm, add; → LINK.
- LINK: a=PC, b=4, add, reg_write, wb_sel=2, pc_write, pc_source=1; → IF.
- HALT: all strobes 0, is_halted=1; holds until reset.
- Any 4-bit state code not listed → IF; all strobes 0 in that cycle.
- retire_cnt increments by 1 on every transition into IF from a non-IF state and wraps modulo 2^CNT_W. Entry into HALT does not count.

## Timing
- Reset: state=IF, retire_cnt=0, is_halted=0. Every strobe is forced to 0 while reset_n=0; IF strobes appear combinationally once reset_n=1.
- Reset asserted mid-instruction (including during a memory wait) aborts immediately; no partial write-back or PC update.
- Cycles with zero wait:
  - R/I: 4.
  - load: 5.
  - store: 5.
  - taken branch: 3; not-taken branch: 4.
  - JAL: 3; JALR: 4.
  - non-exit SYSTEM or illegal: 3.
- Each mem_ready=0 cycle in IF/MEM_RD/MEM_WR adds exactly 1 cycle.
- mem_ready=1 in a non-memory state is ignored.
- Outputs are pure state decode. No output depends on opcode, bcond or mem_ready in the same cycle, except ir_write in IF.

## Structure
- Shared package/header: opcode constants (extend the existing opcodes include), state encoding, alu_src_b/alu_op/wb_sel/pc_source encodings.
- One sub-module, ctrl_decode: combinational state → control word. The top holds the state register, next-state logic, halt flag and retire counter.

## Test plan
- Reset with MEM_HANDSHAKE=1, mem_ready=0: all strobes 0 while reset_n=0. After release: mem_read=1, ir_write=0, state held in IF.
- R-type ADD, mem_ready tied 1 → states IF, ID, EX_R, WB_ALU. reg_write and pc_write both high in cycle 4; retire_cnt 0→1.
- LW with 2 wait cycles in IF and 3 in MEM_RD → 10 cycles total, wb_sel=1 in WB_MEM. SW → mem_write held high for exactly 4 cycles with 3 waits.
- BEQ: bcond=1 → 3 cycles, pc_source=1. bcond=0 → PC_INC follows, 4 cycles.
- ECALL cases:
  - x17_val=10 → HALT; is_halted=1 stays high for 100 cycles, retire_cnt unchanged.
  - x17_val=9 → PC_INC, retire_cnt increments.
  - opcode 7'b1111111 → illegal_op pulses for exactly 1 cycle.
- Assert reset_n=0 in MEM_WR mid-wait → mem_write drops the same cycle. After release: state IF, retire_cnt=0.
